eta6_error_analyzer: RTL and testbench
======================================

# eta6_error_analyzer

Self-contained error-characterisation engine for the 6-bit approximate adder `eta6`. On `start` it sweeps all 4096 operand pairs through an internal `eta6` instance and compares each approximate result with the exact 7-bit sum. It accumulates error count, maximum error distance, total error distance and the first worst-case pair. It sits alongside the approximate-adder library as the on-chip response analyser for its stimulus benches.

## Interface
- `ERR_W`, 19: width of the summed-error-distance accumulator; 19 covers 4096 × 127 without overflow.
- `EXACT_BYPASS`, 0: 1 replaces the `eta6` result with the exact sum, used for analyser self-test.
- `clk`  input  1  single clock, rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  sweep request; sampled in IDLE only.
- `abort`  input  1  terminates a sweep in progress.
- `busy`  output  1  high in RUN and DRAIN.
- `done`  output  1  one-cycle pulse when results are final.
- `valid`  output  1  results correspond to a completed sweep.
- `err_count`  output  13  number of pairs with a nonzero error distance (0..4096).
- `max_ed`  output  7  maximum error distance.
- `sum_ed`  output  ERR_W  sum of error distances.
- `worst_a`, `worst_b`  output  6 each  first pair, in sweep order, achieving `max_ed`.

## Operation
- Pair index `idx[11:0]`: A = `idx[11:6]`, B = `idx[5:0]`; sweep order is 0..4095.
- Exact = A + B, zero-extended to 7 bits. Approx = {COUT, SUM} from `eta6`. ED = |exact − approx|, 7-bit unsigned.
- FSM states:
  - IDLE: on `start` high, clear all results and `valid`, set `idx` = 0, go to RUN.
  - RUN: present `idx` to `eta6`, register ED and the pair into stage register S1, increment `idx`. After `idx` = 4095 is presented, go to DRAIN.
  - DRAIN: accumulate the final S1 entry, go to DONE.
  - DONE: assert `done`, set `valid`, go to IDLE.
- Accumulation (in the cycle after S1 loads, gated by S1-valid):
  - `err_count` += (ED != 0).
  - `sum_ed` += ED.
  - If ED > `max_ed` (strictly greater), update `max_ed`, `worst_a` and `worst_b`.
  - Ties keep the earlier pair.
- `abort` in RUN or DRAIN: go to IDLE next edge and drop S1. Results hold their partial values, `valid` stays 0, and `done` is not pulsed. `abort` in IDLE or DONE has no effect.
- `start` outside IDLE is ignored. If `start` and `abort` are both high in IDLE, `start` wins.
- If `max_ed` stays 0, `worst_a` and `worst_b` remain 0.
- Reset (any time, including mid-sweep): state IDLE; `busy`, `done`, `valid`, all results, `idx` and S1 go to 0.

## Timing
- The edge that samples `start` in IDLE is edge 0.
- `busy` rises after edge 0 and falls after edge 4097.
- Pair `idx` = k is presented during the cycle after edge k and accumulated at edge k+2.
- `done` and `valid` rise after edge 4097. `done` falls after edge 4098; `valid` holds until the next accepted `start` or reset.
- Start-to-done latency is 4098 cycles; a back-to-back `start` is accepted no earlier than edge 4099.
- The `eta6` path is combinational into S1: one adder plus a subtract-absolute within one cycle.

## Structure
- Shared package `eta_pkg`:
  - constants `ETA_W` = 6, `SWEEP_N` = 4096 and `ED_W` = 7;
  - an FSM state enum (IDLE, RUN, DRAIN, DONE).
- Sub-module: one instance of the existing `eta6` (ports A, B, SUM, COUT).
- FSM, sweep counter, S1 register and accumulators live in the top-level module.

## Test plan
- `EXACT_BYPASS` = 1, single `start` pulse → `done` arrives 4098 cycles later, `valid` = 1, `err_count` = 0, `max_ed` = 0, `sum_ed` = 0, `worst_a` = `worst_b` = 0.
- `EXACT_BYPASS` = 0, full sweep → `err_count`, `max_ed`, `sum_ed`, `worst_a` and `worst_b` equal a bench model that evaluates `eta6` over all 4096 pairs, keeping the first maximum. Also checks `err_count` ≤ 4096 and `sum_ed` ≤ 127 × `err_count`.
- `abort` asserted 100 cycles after `start` → `busy` falls the next cycle, no `done` pulse, `valid` = 0. A following `start` produces results identical to the uninterrupted sweep.
- `start` held high continuously → exactly one sweep per 4099 cycles; `start` pulses while `busy` do not change results or the `done` timing.
- `rst_n` low for 1 cycle at edge 2000 of a sweep → all outputs read 0 immediately (asynchronously). A subsequent sweep completes normally with correct results.
- `start` and `abort` both high in IDLE → sweep begins; `abort` and `start` pulses in the DONE cycle are ignored and `done` still pulses for exactly 1 cycle.

Source files
------------

// File: rtl/eta_pkg.sv
// Shared constants and FSM state type for the eta6 approximate-adder family.
package eta_pkg;

   localparam int unsigned ETA_W   = 6;
   localparam int unsigned SWEEP_N = 4096;
   localparam int unsigned ED_W    = 7;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/eta6.sv
// 6-bit error-tolerant adder: exact upper 3 bits without carry-in, lower 3 bits
// XOR-summed from the top down until the first 1+1 position, which saturates itself and all lower bits.
module eta6 (
   input  logic [5:0] A,
   input  logic [5:0] B,
   output logic [5:0] SUM,
   output logic       COUT
);

   localparam int unsigned LO_W = 3;

   logic [LO_W:0]   ctl;
   logic [LO_W-1:0] lo_sum;
   logic [LO_W:0]   hi_sum;

   assign ctl[LO_W] = 1'b0;

   for (genvar g = 0; g < LO_W; g++) begin : g_lo
      assign ctl[g]    = ctl[g+1] | (A[g] & B[g]);
      assign lo_sum[g] = ctl[g] | (A[g] ^ B[g]);
   end

   assign hi_sum = {1'b0, A[5:LO_W]} + {1'b0, B[5:LO_W]};
   assign SUM    = {hi_sum[LO_W-1:0], lo_sum};
   assign COUT   = hi_sum[LO_W];

endmodule

// File: rtl/eta6_error_analyzer.sv
// Exhaustive error characterisation of eta6: sweeps all operand pairs and
// accumulates error count, max/total error distance and first worst-case pair.
module eta6_error_analyzer
   import eta_pkg::*;
#(
   parameter int unsigned ERR_W        = 19,
   parameter bit          EXACT_BYPASS = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic             valid,
   output logic [12:0]      err_count,
   output logic [6:0]       max_ed,
   output logic [ERR_W-1:0] sum_ed,
   output logic [5:0]       worst_a,
   output logic [5:0]       worst_b
);

   localparam logic [11:0] IDX_LAST = 12'(SWEEP_N - 1);

   state_t      state, state_nxt;
   logic [11:0] idx;
   logic        s1_vld;
   logic [6:0]  s1_ed;
   logic [5:0]  s1_a, s1_b;
   logic        clr, ld, acc_en, set_valid;

   logic [5:0]  opa, opb;
   logic [5:0]  apx_sum;
   logic        apx_cout;
   logic [6:0]  exact, approx, ed;

   assign opa = idx[11:6];
   assign opb = idx[5:0];

   eta6 u_eta6 (
      .A    (opa),
      .B    (opb),
      .SUM  (apx_sum),
      .COUT (apx_cout)
   );

   assign exact  = {1'b0, opa} + {1'b0, opb};
   assign approx = EXACT_BYPASS ? exact : {apx_cout, apx_sum};
   assign ed     = (exact >= approx) ? (exact - approx) : (approx - exact);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      clr       = 1'b0;
      ld        = 1'b0;
      acc_en    = 1'b0;
      set_valid = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               clr       = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (abort) begin
               state_nxt = IDLE;
            end else begin
               ld     = 1'b1;
               acc_en = s1_vld;
               if (idx == IDX_LAST) state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            busy = 1'b1;
            if (abort) begin
               state_nxt = IDLE;
            end else begin
               acc_en    = s1_vld;
               set_valid = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx       <= '0;
         s1_vld    <= 1'b0;
         s1_ed     <= '0;
         s1_a      <= '0;
         s1_b      <= '0;
         valid     <= 1'b0;
         err_count <= '0;
         max_ed    <= '0;
         sum_ed    <= '0;
         worst_a   <= '0;
         worst_b   <= '0;
      end else if (clr) begin
         idx       <= '0;
         s1_vld    <= 1'b0;
         valid     <= 1'b0;
         err_count <= '0;
         max_ed    <= '0;
         sum_ed    <= '0;
         worst_a   <= '0;
         worst_b   <= '0;
      end else begin
         // S1 empties whenever no new pair is loaded, which also drops it on abort
         s1_vld <= ld;
         if (ld) begin
            s1_ed <= ed;
            s1_a  <= opa;
            s1_b  <= opb;
            idx   <= idx + 12'd1;
         end
         if (acc_en) begin
            err_count <= err_count + 13'(s1_ed != 7'd0);
            sum_ed    <= sum_ed + ERR_W'(s1_ed);
            if (s1_ed > max_ed) begin
               max_ed  <= s1_ed;
               worst_a <= s1_a;
               worst_b <= s1_b;
            end
         end
         if (set_valid) valid <= 1'b1;
      end
   end

endmodule

// File: tb/tb_eta6_error_analyzer.sv
// Self-checking bench for eta6_error_analyzer against a behavioural sweep model.
module tb_eta6_error_analyzer;

   logic        clk = 1'b0;
   logic        rst_n, start, abort, start_b, abort_b;
   logic        busy, done, valid, busy_x, done_x, valid_x;
   logic [12:0] err_count, err_count_x;
   logic [6:0]  max_ed, max_ed_x;
   logic [18:0] sum_ed, sum_ed_x;
   logic [5:0]  worst_a, worst_b, worst_a_x, worst_b_x;

   int total = 0;
   int bad   = 0;
   int exp_cnt, exp_max, exp_sum, exp_wa, exp_wb;

   always #5 clk = ~clk;

   eta6_error_analyzer #(.ERR_W(19), .EXACT_BYPASS(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .busy(busy), .done(done), .valid(valid),
      .err_count(err_count), .max_ed(max_ed), .sum_ed(sum_ed),
      .worst_a(worst_a), .worst_b(worst_b)
   );

   eta6_error_analyzer #(.ERR_W(19), .EXACT_BYPASS(1'b1)) dut_byp (
      .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
      .busy(busy_x), .done(done_x), .valid(valid_x),
      .err_count(err_count_x), .max_ed(max_ed_x), .sum_ed(sum_ed_x),
      .worst_a(worst_a_x), .worst_b(worst_b_x)
   );

   // Error-tolerant add by its defining rule on integers.
   function automatic int eta_ref(input int a, input int b);
      int  lo;
      bit  sat;
      lo  = 0;
      sat = 1'b0;
      for (int i = 2; i >= 0; i--) begin
         int ai, bi;
         ai = (a >> i) & 1;
         bi = (b >> i) & 1;
         if (ai == 1 && bi == 1) sat = 1'b1;
         if (sat || ai != bi) lo += (1 << i);
      end
      return ((a / 8) + (b / 8)) * 8 + lo;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_busy"},  64'(busy),      64'd0);
      chk({tag, "_done"},  64'(done),      64'd0);
      chk({tag, "_valid"}, 64'(valid),     64'd0);
      chk({tag, "_cnt"},   64'(err_count), 64'd0);
      chk({tag, "_max"},   64'(max_ed),    64'd0);
      chk({tag, "_sum"},   64'(sum_ed),    64'd0);
      chk({tag, "_wa"},    64'(worst_a),   64'd0);
      chk({tag, "_wb"},    64'(worst_b),   64'd0);
   endtask

   task automatic check_full(input string tag);
      chk({tag, "_valid"}, 64'(valid),     64'd1);
      chk({tag, "_cnt"},   64'(err_count), 64'(exp_cnt));
      chk({tag, "_max"},   64'(max_ed),    64'(exp_max));
      chk({tag, "_sum"},   64'(sum_ed),    64'(exp_sum));
      chk({tag, "_wa"},    64'(worst_a),   64'(exp_wa));
      chk({tag, "_wb"},    64'(worst_b),   64'(exp_wb));
      chk({tag, "_cnt_le_4096"}, 64'(err_count <= 13'd4096), 64'd1);
      chk({tag, "_sum_bound"}, 64'(64'(sum_ed) <= 64'd127 * 64'(err_count)), 64'd1);
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < 5000) begin
         tick();
         n++;
      end
   endtask

   initial begin
      int n, ndone, t1, t2;
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; start_b = 1'b0; abort_b = 1'b0;

      exp_cnt = 0; exp_max = 0; exp_sum = 0; exp_wa = 0; exp_wb = 0;
      for (int a = 0; a < 64; a++) begin
         for (int b = 0; b < 64; b++) begin
            int ed;
            ed = (a + b) - eta_ref(a, b);
            if (ed < 0) ed = -ed;
            if (ed != 0) exp_cnt++;
            exp_sum += ed;
            if (ed > exp_max) begin
               exp_max = ed; exp_wa = a; exp_wb = b;
            end
         end
      end

      repeat (3) tick();
      check_zero("rst");
      chk("rst_byp_valid", 64'(valid_x), 64'd0);
      rst_n = 1'b1;
      tick();

      // Full sweep on both instances, with random start pulses on the main one while busy
      start = 1'b1; start_b = 1'b1;
      tick();
      start = 1'b0; start_b = 1'b0;
      chk("sweep1_busy", 64'(busy), 64'd1);
      chk("byp_busy", 64'(busy_x), 64'd1);
      n = 0;
      while (!done && n < 5000) begin
         start = ($urandom_range(0, 7) == 0);
         tick();
         n++;
      end
      start = 1'b0;
      chk("sweep1_latency", 64'(n), 64'd4097);
      chk("sweep1_busy_dn", 64'(busy), 64'd0);
      chk("byp_done", 64'(done_x), 64'd1);
      check_full("sweep1");
      chk("byp_valid", 64'(valid_x), 64'd1);
      chk("byp_cnt", 64'(err_count_x), 64'd0);
      chk("byp_max", 64'(max_ed_x), 64'd0);
      chk("byp_sum", 64'(sum_ed_x), 64'd0);
      chk("byp_wa", 64'(worst_a_x), 64'd0);
      chk("byp_wb", 64'(worst_b_x), 64'd0);
      tick();
      chk("sweep1_done_1cyc", 64'(done), 64'd0);
      chk("sweep1_valid_hold", 64'(valid), 64'd1);

      // Abort 100 cycles into a sweep
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (99) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_valid", 64'(valid), 64'd0);
      ndone = 0;
      for (int i = 0; i < 200; i++) begin
         if (done || valid) ndone++;
         tick();
      end
      chk("abort_no_done", 64'(ndone), 64'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(n);
      chk("after_abort_latency", 64'(n), 64'd4097);
      check_full("after_abort");
      tick();

      // start held high: one sweep every 4099 cycles
      start = 1'b1;
      tick();
      n = 0; ndone = 0; t1 = 0; t2 = 0;
      while (ndone < 2 && n < 9000) begin
         tick();
         n++;
         if (done) begin
            ndone++;
            if (ndone == 1) t1 = n;
            else t2 = n;
         end
      end
      start = 1'b0;
      chk("held_first_done", 64'(t1), 64'd4097);
      chk("held_second_done", 64'(t2), 64'd8196);
      check_full("held");
      tick();
      chk("held_idle", 64'(busy), 64'd0);

      // Asynchronous reset at edge 2000 of a sweep
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (2000) tick();
      chk("pre_rst_busy", 64'(busy), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check_zero("async_rst");
      @(posedge clk);
      #1 rst_n = 1'b1;
      check_zero("rst_release");
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(n);
      chk("after_rst_latency", 64'(n), 64'd4097);
      check_full("after_rst");
      tick();

      // start+abort together in IDLE starts; both in DONE are ignored
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      chk("start_wins_busy", 64'(busy), 64'd1);
      wait_done(n);
      chk("start_wins_latency", 64'(n), 64'd4097);
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      chk("done_ign_done", 64'(done), 64'd0);
      chk("done_ign_busy", 64'(busy), 64'd0);
      check_full("done_ign");
      tick();
      chk("done_ign_still_idle", 64'(busy), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
